// File: rtl/rot_arbiter.sv
// rot_arbiter: two requesters share one 16-bit rotate-left unit.
// Requests are arbitrated round-robin. The winner's operand is latched, the
// rotator is held busy for HOLD_CYCLES cycles, and the result is then
// presented with valid/ready backpressure.
//
// state | meaning
// IDLE  | no operation in flight; a pending request is granted combinationally
// BUSY  | operand latched, rotator held for HOLD_CYCLES cycles
// DONE  | result presented on res_*, waiting for res_ready
module rot_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic [3:0]  amt0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [15:0] data1,
    input  logic [3:0]  amt1,
    output logic        gnt1,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_id,
    input  logic        res_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

    state_t      state;
    logic        ptr;
    logic [3:0]  cnt;
    logic [15:0] op_data;
    logic [3:0]  op_amt;
    logic        op_id;

    logic        grant_any;
    logic        grant_id;
    logic [31:0] rot_wide;
    logic [15:0] rot_result;

    // Arbitration: grant is decided in the IDLE cycle itself so that the
    // operand is captured on the same edge that ends the grant pulse.
    // A lone request wins outright; a tie goes to the requester named by ptr.
    always_comb begin
        grant_any = (state == IDLE) && !rst && (req0 || req1);
        if (req0 && req1) begin
            grant_id = ptr;
        end else begin
            grant_id = req1;
        end
    end

    assign gnt0 = grant_any && !grant_id;
    assign gnt1 = grant_any && grant_id;

    // Shared rotator fed only from the operand registers. Doubling the word
    // and keeping the upper half gives a rotate-left; amt=0 passes through.
    assign rot_wide   = {op_data, op_data} << op_amt;
    assign rot_result = rot_wide[31:16];

    // Sequencing FSM, operand capture, hold counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cnt       <= 4'd0;
            op_data   <= 16'h0000;
            op_amt    <= 4'd0;
            op_id     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_data <= grant_id ? data1 : data0;
                        op_amt  <= grant_id ? amt1 : amt0;
                        op_id   <= grant_id;
                        ptr     <= ~grant_id;
                        cnt     <= HOLD_M1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= rot_result;
                        res_id    <= op_id;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rot_arbiter.sv
// Bench for rot_arbiter: scoreboard with a transaction-level reference model
// on the default instance, plus two extra instances for the latency extremes.
module tb_rot_arbiter;

    localparam int H = 2;

    logic        clk;
    logic        rst;
    logic        req0, req1, res_ready;
    logic [15:0] data0, data1;
    logic [3:0]  amt0, amt1;
    logic        gnt0, gnt1, res_valid, res_id;
    logic [15:0] res_data;

    logic        req0_h1, gnt0_h1, gnt1_h1, res_valid_h1, res_id_h1;
    logic [15:0] data0_h1, res_data_h1;
    logic [3:0]  amt0_h1;
    logic        req0_h15, gnt0_h15, gnt1_h15, res_valid_h15, res_id_h15;
    logic [15:0] data0_h15, res_data_h15;
    logic [3:0]  amt0_h15;
    logic        idle_req;
    logic [15:0] idle_data;
    logic [3:0]  idle_amt;
    logic        ready_hi;

    int tests = 0;
    int fails = 0;

    rot_arbiter #(.HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .amt0(amt0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .amt1(amt1), .gnt1(gnt1),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready)
    );

    rot_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst(rst),
        .req0(req0_h1), .data0(data0_h1), .amt0(amt0_h1), .gnt0(gnt0_h1),
        .req1(idle_req), .data1(idle_data), .amt1(idle_amt), .gnt1(gnt1_h1),
        .res_valid(res_valid_h1), .res_data(res_data_h1), .res_id(res_id_h1),
        .res_ready(ready_hi)
    );

    rot_arbiter #(.HOLD_CYCLES(15)) dut_h15 (
        .clk(clk), .rst(rst),
        .req0(req0_h15), .data0(data0_h15), .amt0(amt0_h15), .gnt0(gnt0_h15),
        .req1(idle_req), .data1(idle_data), .amt1(idle_amt), .gnt1(gnt1_h15),
        .res_valid(res_valid_h15), .res_data(res_data_h15), .res_id(res_id_h15),
        .res_ready(ready_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference rotate: result bit i takes operand bit (i - amt) mod 16.
    function automatic logic [15:0] ref_rotl(logic [15:0] x, int amt);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[(i - amt + 16) % 16];
        return r;
    endfunction

    typedef struct {
        logic [15:0] d;
        logic        id;
        int          gcyc;
    } exp_t;

    exp_t q[$];
    logic m_ptr = 1'b0;
    bit   after_rst = 1'b0;
    int   cyc = 0;

    // Scoreboard monitor: model decides when a grant must occur and who wins,
    // pushes the expected result, and checks every presented result.
    always @(negedge clk) begin
        bit   idle_now;
        bit   exp_valid;
        bit   exp_grant;
        logic exp_id;
        exp_t e;
        cyc++;
        if (after_rst) begin
            chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
            chk("rst_res_data", {16'd0, res_data}, 32'd0);
            chk("rst_res_id", {31'd0, res_id}, 32'd0);
            after_rst = 1'b0;
        end
        chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
        idle_now  = (q.size() == 0);
        exp_valid = !idle_now && (cyc >= q[0].gcyc + 1 + H);
        chk("res_valid", {31'd0, res_valid}, {31'd0, exp_valid});
        if (exp_valid && res_valid) begin
            chk("res_data", {16'd0, res_data}, {16'd0, q[0].d});
            chk("res_id", {31'd0, res_id}, {31'd0, q[0].id});
            if (res_ready) void'(q.pop_front());
        end
        exp_grant = !rst && idle_now && (req0 || req1);
        chk("grant_present", {31'd0, gnt0 | gnt1}, {31'd0, exp_grant});
        if (exp_grant) begin
            exp_id = (req0 && req1) ? m_ptr : req1;
            chk("grant_id", {30'd0, gnt1, gnt0}, exp_id ? 32'd2 : 32'd1);
            e.id   = exp_id;
            e.d    = exp_id ? ref_rotl(data1, int'(amt1)) : ref_rotl(data0, int'(amt0));
            e.gcyc = cyc;
            q.push_back(e);
            m_ptr = ~exp_id;
        end
        if (rst) begin
            q.delete();
            m_ptr = 1'b0;
            after_rst = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from requester id and wait for its handshake.
    task automatic do_op(input logic id, input logic [15:0] d, input logic [3:0] a);
        bit got;
        bit done;
        got = 1'b0;
        done = 1'b0;
        if (id) begin req1 = 1'b1; data1 = d; amt1 = a; end
        else    begin req0 = 1'b1; data0 = d; amt0 = a; end
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            got = id ? gnt1 : gnt0;
            tick();
        end
        chk("op_grant_seen", {31'd0, got}, 32'd1);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            done = res_valid && res_ready;
            tick();
        end
        chk("op_done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int   t1g, t1v, t15g, t15v;
        bit   g0, g1, seen;
        logic [15:0] rd;
        logic        ri;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
        data0 = 16'h0; data1 = 16'h0; amt0 = 4'd0; amt1 = 4'd0;
        req0_h1 = 1'b0; data0_h1 = 16'h0; amt0_h1 = 4'd0;
        req0_h15 = 1'b0; data0_h15 = 16'h0; amt0_h15 = 4'd0;
        idle_req = 1'b0; idle_data = 16'h0; idle_amt = 4'd0; ready_hi = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Latency extremes on the HOLD_CYCLES=1 and 15 instances.
        t1g = -1; t1v = -1; t15g = -1; t15v = -1;
        req0_h1 = 1'b1;  data0_h1 = 16'h1234;  amt0_h1 = 4'd3;
        req0_h15 = 1'b1; data0_h15 = 16'hF00D; amt0_h15 = 4'd15;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt0_h1 && t1g < 0) t1g = k;
            if (gnt0_h15 && t15g < 0) t15g = k;
            if (res_valid_h1 && t1v < 0) begin
                t1v = k;
                chk("h1_data", {16'd0, res_data_h1}, {16'd0, ref_rotl(16'h1234, 3)});
            end
            if (res_valid_h15 && t15v < 0) begin
                t15v = k;
                chk("h15_data", {16'd0, res_data_h15}, {16'd0, ref_rotl(16'hF00D, 15)});
            end
            tick();
            if (t1g >= 0) req0_h1 = 1'b0;
            if (t15g >= 0) req0_h15 = 1'b0;
        end
        chk("h1_latency", t1v - t1g, 32'd2);
        chk("h15_latency", t15v - t15g, 32'd16);

        // Directed operations on the default instance.
        res_ready = 1'b1;
        do_op(1'b0, 16'h0001, 4'd4);
        do_op(1'b1, 16'h8001, 4'd1);
        do_op(1'b0, 16'hA5C3, 4'd0);
        do_op(1'b1, 16'hA5C3, 4'd0);

        // Both requesters held high: grants must alternate.
        req0 = 1'b1; req1 = 1'b1;
        data0 = 16'($urandom); amt0 = 4'($urandom);
        data1 = 16'($urandom); amt1 = 4'($urandom);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            tick();
            if (g0) begin data0 = 16'($urandom); amt0 = 4'($urandom); end
            if (g1) begin data1 = 16'($urandom); amt1 = 4'($urandom); end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) tick();

        // Backpressure: result held for 5 cycles, pending request waits.
        res_ready = 1'b0;
        req0 = 1'b1; data0 = 16'h1357; amt0 = 4'd9;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = gnt0;
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b1; data1 = 16'hBEEF; amt1 = 4'd5;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) begin seen = 1'b1; break; end
            tick();
        end
        chk("bp_valid_seen", {31'd0, seen}, 32'd1);
        rd = res_data; ri = res_id;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("bp_valid_hold", {31'd0, res_valid}, 32'd1);
            chk("bp_data_hold", {16'd0, res_data}, {16'd0, rd});
            chk("bp_id_hold", {31'd0, res_id}, {31'd0, ri});
            chk("bp_no_gnt", {31'd0, gnt0 | gnt1}, 32'd0);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_no_gnt", {31'd0, gnt1}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_pending_granted", {31'd0, gnt1}, 32'd1);
        tick();
        req1 = 1'b0;
        repeat (6) tick();

        // Reset during the second BUSY cycle discards the operation.
        req0 = 1'b1; data0 = 16'h00FF; amt0 = 4'd2;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = gnt0;
            tick();
        end
        req0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        repeat (6) tick();
        req0 = 1'b1; req1 = 1'b1;
        data0 = 16'h4321; amt0 = 4'd7; data1 = 16'h8765; amt1 = 4'd11;
        @(negedge clk);
        chk("rst_ptr_zero", {30'd0, gnt1, gnt0}, 32'd1);
        tick();
        req0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            g1 = gnt1;
            tick();
            if (g1) req1 = 1'b0;
        end
        req1 = 1'b0;
        repeat (6) tick();

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            tick();
            if (req0 && g0) begin
                req0 = ($urandom_range(1, 0) == 1);
                data0 = 16'($urandom); amt0 = 4'($urandom);
            end else if (!req0 && $urandom_range(9, 0) < 4) begin
                req0 = 1'b1; data0 = 16'($urandom); amt0 = 4'($urandom);
            end
            if (req1 && g1) begin
                req1 = ($urandom_range(1, 0) == 1);
                data1 = 16'($urandom); amt1 = 4'($urandom);
            end else if (!req1 && $urandom_range(9, 0) < 4) begin
                req1 = 1'b1; data1 = 16'($urandom); amt1 = 4'($urandom);
            end
            res_ready = ($urandom_range(2, 0) != 0);
        end

        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
        repeat (20) tick();
        chk("drain_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
